simulador_reservatorio: RTL and testbench
=========================================

// Module: simulador_reservatorio
// PURPOSE
//   Plant model for the water tank: consumes the actuator commands from the tank/irrigation
//   controller (Ve, Gotejamento, Aspersao) and produces the level-sensor inputs it reads
//   (Alta, Media, Baixa). Closes the loop on the FPGA board and in simulation.
//   Internal level counter, prescaled update tick, saturating arithmetic, flow-state FSM.
// PARAMETERS
//   NIVEL_W    8     level register width (bits)
//   NIVEL_MAX  200   full-tank level; must be < 2**NIVEL_W
//   NIVEL_INI  120   level loaded at reset; 0 < NIVEL_INI <= NIVEL_MAX
//   LIM_BAIXA  40    Baixa threshold (Nivel >= LIM_BAIXA)
//   LIM_MEDIA  100   Media threshold; LIM_BAIXA < LIM_MEDIA < LIM_ALTA
//   LIM_ALTA   170   Alta threshold; LIM_ALTA <= NIVEL_MAX
//   TICK_DIV   1000  Clock cycles per level update; >= 2
//   VAZAO_VE   3     level units added per tick while Ve=1
//   VAZAO_GOT  1     units removed per tick while Gotejamento=1
//   VAZAO_ASP  2     units removed per tick while Aspersao=1
// PORTS
//   Clock        in   1        system clock
//   Reset_n      in   1        synchronous, active-low reset
//   Ve           in   1        inlet valve open
//   Gotejamento  in   1        drip irrigation active (drains tank)
//   Aspersao     in   1        sprinkler active (drains tank)
//   Alta         out  1        high sensor
//   Media        out  1        mid sensor
//   Baixa        out  1        low sensor
//   Nivel        out  NIVEL_W  current level (registered)
//   Estado       out  2        00 PARADO, 01 ENCHENDO, 10 ESVAZIANDO, 11 TRANSBORDANDO
//   Transbordo   out  1        sticky overflow flag
//   Seco         out  1        Nivel == 0
// BEHAVIOUR
//   Single clock, Clock. Reset_n is synchronous and active-low; every register is sampled on the rising edge of Clock.
//   Reset (Reset_n=0 at an edge): prescaler=0, Nivel=NIVEL_INI, Estado=PARADO, Transbordo=0, Seco=0.
//     Sensors take the values derived from NIVEL_INI at that edge. Mid-run reset aborts a pending tick.
//   Prescaler counts 0..TICK_DIV-1 and wraps. tick=1 on the cycle where count==TICK_DIV-1.
//   On the tick edge: delta = Ve*VAZAO_VE - Gotejamento*VAZAO_GOT - Aspersao*VAZAO_ASP.
//     delta is signed, NIVEL_W+2 bits. sum = Nivel + delta.
//     Inputs are sampled only on that edge; pulses between ticks are ignored.
//   Saturation: sum<0 -> Nivel=0. sum>NIVEL_MAX -> Nivel=NIVEL_MAX and Transbordo=1.
//     Transbordo stays set until reset. Otherwise Nivel=sum.
//   FSM, updated only on the tick edge:
//     sum>NIVEL_MAX -> TRANSBORDANDO
//     else delta>0 -> ENCHENDO
//     else delta<0 -> ESVAZIANDO
//     else PARADO. Simultaneous inflow/outflow nets out (e.g. Ve+Asp+Got = 0 -> PARADO).
//   Sensors, Seco: registered from the registered Nivel. One cycle latency after the Nivel update.
//     Alta=(Nivel>=LIM_ALTA), Media=(Nivel>=LIM_MEDIA), Baixa=(Nivel>=LIM_BAIXA), Seco=(Nivel==0).
//     Sensor pattern is always thermometer-consistent (Alta implies Media implies Baixa) unless fault injection is active.
// CONFIGURATION
//   FALHA_SENSOR_EN defined: adds input Falha[1:0], sampled every cycle.
//     00 none, 01 Media stuck 0, 10 Baixa stuck 0, 11 Alta stuck 1.
//     Applied after sensor registers (same latency). Nivel, Estado and flags are unaffected.
//     Exercises the controller's Erro detection.
//   FALHA_SENSOR_EN undefined: no Falha port; sensors are always consistent.
// TESTING
//   All cases use TICK_DIV=4 and default flows.
//   1 Reset, then Ve=0/Got=0/Asp=0 for 40 cycles
//     -> Nivel=120, Media=1, Alta=0, Baixa=1, Estado=PARADO.
//   2 Ve=1 only -> Nivel +3 every 4 cycles, Estado=ENCHENDO.
//     Alta rises 1 cycle after Nivel reaches >=170 (tick 17, Nivel=171).
//     Continue -> Nivel clamps at 200, Transbordo=1, TRANSBORDANDO.
//     Then Ve=0 -> Transbordo stays 1.
//   3 From 120: Asp=1, Got=1 -> -3 per tick, ESVAZIANDO.
//     Baixa falls when Nivel<40. After 40 ticks Nivel=0, Seco=1. Further ticks hold 0.
//   4 Ve=1, Got=1, Asp=1 -> delta=0, Nivel constant, PARADO.
//     Toggle Ve for one non-tick cycle -> no change.
//   5 Reset_n=0 mid-fill at Nivel=150 for 1 cycle
//     -> next edge Nivel=120, prescaler=0, Transbordo=0. First tick 4 cycles after release.
//   6 FALHA_SENSOR_EN, Nivel=180, Falha=01 -> Alta=1, Media=0 after 1 cycle.
//     Falha=00 -> Media=1 after 1 cycle.

Source files
------------

// File: rtl/simulador_reservatorio.sv
// -----------------------------------------------------------------------------
// simulador_reservatorio
//   Plant model of the water tank. Integrates the actuator commands coming
//   from the tank/irrigation controller into a level counter, and produces the
//   level-sensor signals that controller reads back.
//
//   The level is only updated on a prescaled tick. On that tick the level is
//   moved by the net flow and saturated to [0, NIVEL_MAX]. A small flow-state
//   machine reports the direction of the last update.
//
//   Optional feature: define FALHA_SENSOR_EN to add the Falha[1:0] input, which
//   forces sensor faults for exercising the controller's error detection.
//
// Ports
//   Clock        in   system clock
//   Reset_n      in   synchronous active-low reset
//   Ve           in   inlet valve open (+VAZAO_VE per tick)
//   Gotejamento  in   drip irrigation (-VAZAO_GOT per tick)
//   Aspersao     in   sprinkler (-VAZAO_ASP per tick)
//   Falha        in   [1:0] sensor fault select (FALHA_SENSOR_EN only)
//   Alta         out  Nivel >= LIM_ALTA   (one cycle behind Nivel)
//   Media        out  Nivel >= LIM_MEDIA  (one cycle behind Nivel)
//   Baixa        out  Nivel >= LIM_BAIXA  (one cycle behind Nivel)
//   Nivel        out  [NIVEL_W-1:0] current level
//   Estado       out  [1:0] 00 PARADO, 01 ENCHENDO, 10 ESVAZIANDO, 11 TRANSBORDANDO
//   Transbordo   out  sticky overflow flag, cleared only by reset
//   Seco         out  Nivel == 0          (one cycle behind Nivel)
// -----------------------------------------------------------------------------
module simulador_reservatorio #(
  parameter int NIVEL_W   = 8,
  parameter int NIVEL_MAX = 200,
  parameter int NIVEL_INI = 120,
  parameter int LIM_BAIXA = 40,
  parameter int LIM_MEDIA = 100,
  parameter int LIM_ALTA  = 170,
  parameter int TICK_DIV  = 1000,
  parameter int VAZAO_VE  = 3,
  parameter int VAZAO_GOT = 1,
  parameter int VAZAO_ASP = 2
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Ve,
  input  logic               Gotejamento,
  input  logic               Aspersao,
`ifdef FALHA_SENSOR_EN
  input  logic [1:0]         Falha,
`endif
  output logic               Alta,
  output logic               Media,
  output logic               Baixa,
  output logic [NIVEL_W-1:0] Nivel,
  output logic [1:0]         Estado,
  output logic               Transbordo,
  output logic               Seco
);

  localparam int DW = NIVEL_W + 2;           // signed width of delta / sum
  localparam int PW = $clog2(TICK_DIV);

  localparam logic [1:0] S_PARADO        = 2'b00;
  localparam logic [1:0] S_ENCHENDO      = 2'b01;
  localparam logic [1:0] S_ESVAZIANDO    = 2'b10;
  localparam logic [1:0] S_TRANSBORDANDO = 2'b11;

  logic [PW-1:0]      r_presc;
  logic [NIVEL_W-1:0] r_nivel;
  logic [1:0]         r_estado;
  logic               r_transbordo;
  logic               r_alta, r_media, r_baixa, r_seco;

  logic               w_tick;
  logic signed [DW-1:0] w_delta, w_sum;
  logic               w_over, w_under;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  // Net flow; opposing commands cancel arithmetically.
  always_comb begin
    w_delta = '0;
    if (Ve)          w_delta = w_delta + $signed(DW'(VAZAO_VE));
    if (Gotejamento) w_delta = w_delta - $signed(DW'(VAZAO_GOT));
    if (Aspersao)    w_delta = w_delta - $signed(DW'(VAZAO_ASP));
  end

  assign w_sum   = $signed({2'b00, r_nivel}) + w_delta;
  assign w_under = w_sum[DW-1];
  assign w_over  = (w_sum > $signed(DW'(NIVEL_MAX)));

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_presc      <= '0;
      r_nivel      <= NIVEL_W'(NIVEL_INI);
      r_estado     <= S_PARADO;
      r_transbordo <= 1'b0;
      // Sensors come up already consistent with the reset level.
      r_alta       <= (NIVEL_INI >= LIM_ALTA);
      r_media      <= (NIVEL_INI >= LIM_MEDIA);
      r_baixa      <= (NIVEL_INI >= LIM_BAIXA);
      r_seco       <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;

      if (w_tick) begin
        if (w_over) begin
          r_nivel      <= NIVEL_W'(NIVEL_MAX);
          r_transbordo <= 1'b1;
          r_estado     <= S_TRANSBORDANDO;
        end else begin
          r_nivel <= w_under ? '0 : w_sum[NIVEL_W-1:0];
          if (w_delta > 0)      r_estado <= S_ENCHENDO;
          else if (w_delta < 0) r_estado <= S_ESVAZIANDO;
          else                  r_estado <= S_PARADO;
        end
      end

      // Sensors follow the registered level, so they lag Nivel by one cycle.
      r_alta  <= (r_nivel >= NIVEL_W'(LIM_ALTA));
      r_media <= (r_nivel >= NIVEL_W'(LIM_MEDIA));
      r_baixa <= (r_nivel >= NIVEL_W'(LIM_BAIXA));
      r_seco  <= (r_nivel == '0);
    end
  end

  assign Nivel      = r_nivel;
  assign Estado     = r_estado;
  assign Transbordo = r_transbordo;
  assign Seco       = r_seco;

`ifdef FALHA_SENSOR_EN
  // Fault select is registered so the forced value lines up with the
  // sensor registers (one cycle after Falha changes).
  logic [1:0] r_falha;

  always_ff @(posedge Clock) begin
    if (!Reset_n) r_falha <= 2'b00;
    else          r_falha <= Falha;
  end

  assign Alta  = r_alta  | (r_falha == 2'b11);
  assign Media = r_media & (r_falha != 2'b01);
  assign Baixa = r_baixa & (r_falha != 2'b10);
`else
  assign Alta  = r_alta;
  assign Media = r_media;
  assign Baixa = r_baixa;
`endif

endmodule

// File: tb/tb_simulador_reservatorio.sv
// Scoreboard bench: the driver applies one cycle of stimulus, advances a
// behavioural tank model by one clock and queues the expected outputs; the
// monitor pops one entry after every rising edge and compares.
module tb_simulador_reservatorio;

  localparam int NMAX = 200, NINI = 120, LB = 40, LM = 100, LA = 170, TDIV = 4;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0, Ve = 1'b0, Gotejamento = 1'b0, Aspersao = 1'b0;
  logic       Alta, Media, Baixa, Transbordo, Seco;
  logic [7:0] Nivel;
  logic [1:0] Estado;

  always #5 Clock = ~Clock;

  simulador_reservatorio #(.TICK_DIV(TDIV)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Ve(Ve), .Gotejamento(Gotejamento),
    .Aspersao(Aspersao), .Alta(Alta), .Media(Media), .Baixa(Baixa),
    .Nivel(Nivel), .Estado(Estado), .Transbordo(Transbordo), .Seco(Seco)
  );

  typedef struct packed {
    logic [7:0] lvl;
    logic [1:0] est;
    logic       tr, alta, media, baixa, seco;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  bit   done = 0;

  // Reference model state (plain integers).
  int m_cnt, m_lvl, m_est;
  bit m_tr, m_a, m_m, m_b, m_s;

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input bit rst_n, input bit ve, input bit got, input bit asp);
    int d, s;
    if (!rst_n) begin
      m_cnt = 0; m_lvl = NINI; m_est = 0; m_tr = 0;
      m_a = (NINI >= LA); m_m = (NINI >= LM); m_b = (NINI >= LB); m_s = 0;
    end else begin
      // sensors see the level as it stood before this edge
      m_a = (m_lvl >= LA); m_m = (m_lvl >= LM); m_b = (m_lvl >= LB); m_s = (m_lvl == 0);
      if (m_cnt == TDIV - 1) begin
        m_cnt = 0;
        d = 3 * int'(ve) - int'(got) - 2 * int'(asp);
        s = m_lvl + d;
        if (s > NMAX) begin
          m_lvl = NMAX; m_tr = 1; m_est = 3;
        end else begin
          m_lvl = (s < 0) ? 0 : s;
          m_est = (d > 0) ? 1 : (d < 0) ? 2 : 0;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic drive(input bit rst_n, input bit ve, input bit got, input bit asp);
    exp_t e;
    Reset_n = rst_n; Ve = ve; Gotejamento = got; Aspersao = asp;
    model_step(rst_n, ve, got, asp);
    e.lvl = 8'(m_lvl); e.est = 2'(m_est); e.tr = m_tr;
    e.alta = m_a; e.media = m_m; e.baixa = m_b; e.seco = m_s;
    q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic run(input int n, input bit ve, input bit got, input bit asp);
    for (int i = 0; i < n; i++) drive(1'b1, ve, got, asp);
  endtask

  // Monitor: one expected entry per rising edge, sampled 2 ns after it.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge Clock);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {Nivel, Estado, Transbordo, Alta, Media, Baixa, Seco};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_check t=%0t got lvl=%0d est=%0d tr=%0b A/M/B/S=%0b%0b%0b%0b expected lvl=%0d est=%0d tr=%0b A/M/B/S=%0b%0b%0b%0b",
                   $time, a.lvl, a.est, a.tr, a.alta, a.media, a.baixa, a.seco,
                   e.lvl, e.est, e.tr, e.alta, e.media, e.baixa, e.seco);
        end
      end
    end
  end

  initial begin
    // 1: reset, then idle
    drive(1'b0, 0, 0, 0);
    drive(1'b0, 0, 0, 0);
    run(40, 0, 0, 0);
    // 2: fill until overflow, then close the valve (Transbordo must stay)
    run(4 * 32, 1, 0, 0);
    run(20, 0, 0, 0);
    // 3: drain from 120 to dry and beyond
    drive(1'b0, 0, 0, 0);
    run(4 * 45, 0, 1, 1);
    // 4: balanced flows, with a single-cycle Ve glitch away from the tick
    drive(1'b0, 0, 0, 0);
    run(5, 1, 1, 1);
    drive(1'b1, 0, 1, 1);
    run(30, 1, 1, 1);
    // 5: mid-fill reset at 150, then resume filling
    drive(1'b0, 0, 0, 0);
    run(40, 1, 0, 0);
    drive(1'b0, 1, 0, 0);
    run(20, 1, 0, 0);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      drive(($urandom_range(0, 199) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
    // let the monitor drain the queue, bounded
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge Clock);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    if (checks < 3000) begin
      errors++;
      $display("FAIL check_count got=%0d expected >=3000", checks);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
